// File: rtl/soc_periph_demux.sv
// rtl/soc_periph_demux.sv - in-order req/gnt/rvalid demux from the core bus to the SoC slaves
//
// Purpose: decodes each upstream request against the fixed SoC address map,
// forwards it to one of 11 slaves (or to an internal error responder for
// unmapped addresses), and keeps responses in order by only switching target
// once every outstanding transaction of the previous target has answered.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i  upstream request (held until gnt_o)
//   gnt_o                        request accepted this cycle
//   rvalid_o/rdata_o/err_o       upstream response
//   slv_req_o, slv_gnt_i         per-slave request/grant
//   slv_addr_o/slv_we_o/slv_be_o/slv_wdata_o  broadcast request fields
//   slv_rvalid_i/slv_rdata_i/slv_err_i        per-slave response
//                                (slv_rdata_i is NumSlaves*DataWidth, slave i at [i*DataWidth +: DataWidth])
//
// Optional feature (macro SOC_PERIPH_DEMUX_ERR_CAPTURE_EN): adds err_valid_o,
// err_addr_o and err_clr_i, a sticky record of the first failing address.

module soc_periph_demux #(
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned NumSlaves      = 11,
    parameter logic [63:0] ErrData        = 64'hBADC_AB1E_BADC_AB1E
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    input  logic [AddrWidth-1:0]           addr_i,
    input  logic                           we_i,
    input  logic [DataWidth/8-1:0]         be_i,
    input  logic [DataWidth-1:0]           wdata_i,
    output logic                           gnt_o,
    output logic                           rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           err_o,
    output logic [NumSlaves-1:0]           slv_req_o,
    output logic [AddrWidth-1:0]           slv_addr_o,
    output logic                           slv_we_o,
    output logic [DataWidth/8-1:0]         slv_be_o,
    output logic [DataWidth-1:0]           slv_wdata_o,
    input  logic [NumSlaves-1:0]           slv_gnt_i,
    input  logic [NumSlaves-1:0]           slv_rvalid_i,
    input  logic [NumSlaves*DataWidth-1:0] slv_rdata_i,
    input  logic [NumSlaves-1:0]           slv_err_i
`ifdef SOC_PERIPH_DEMUX_ERR_CAPTURE_EN
    ,
    output logic                           err_valid_o,
    output logic [AddrWidth-1:0]           err_addr_o,
    input  logic                           err_clr_i
`endif
);

    localparam int unsigned CntW   = $clog2(NumOutstanding + 1);
    // One extra bit above the address so base + length never wraps.
    localparam int unsigned CmpW   = ((AddrWidth > 64) ? AddrWidth : 64) + 1;
    localparam logic [3:0]  TgtErr = 4'd11;

    function automatic logic in_range(input logic [CmpW-1:0] a,
                                      input logic [63:0]     base,
                                      input logic [63:0]     len);
        logic [CmpW-1:0] lo;
        logic [CmpW-1:0] hi;
        lo = CmpW'(base);
        hi = CmpW'(base) + CmpW'(len);
        return (a >= lo) && (a < hi);
    endfunction

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      cur_tgt_q, cur_tgt_d;
    logic            err_rvalid_q, err_rvalid_d;

    logic [CmpW-1:0]      addr_ext;
    logic [3:0]           target;
    logic                 stall;
    logic                 rvalid_dec;
    logic [NumSlaves-1:0] cur_mask;

    // Address decode
    always_comb begin
        addr_ext = CmpW'(addr_i);
        target   = TgtErr;
        if (in_range(addr_ext, 64'h0000_0000, 64'h0000_1000)) target = 4'd10;
        if (in_range(addr_ext, 64'h0001_0000, 64'h0001_0000)) target = 4'd9;
        if (in_range(addr_ext, 64'h0200_0000, 64'h000C_0000)) target = 4'd8;
        if (in_range(addr_ext, 64'h0C00_0000, 64'h03FF_FFFF)) target = 4'd7;
        if (in_range(addr_ext, 64'h1000_0000, 64'h0000_1000)) target = 4'd6;
        if (in_range(addr_ext, 64'h1800_0000, 64'h0000_1000)) target = 4'd5;
        if (in_range(addr_ext, 64'h2000_0000, 64'h0080_0000)) target = 4'd4;
        if (in_range(addr_ext, 64'h3000_0000, 64'h0001_0000)) target = 4'd3;
        if (in_range(addr_ext, 64'h4000_0000, 64'h0000_1000)) target = 4'd2;
        if (in_range(addr_ext, 64'h5000_0000, 64'h03FF_FFFF)) target = 4'd0;
        if (in_range(addr_ext, 64'h8000_0000, 64'h4000_0000)) target = 4'd1;
    end

    // A different target is only accepted once everything in flight has
    // answered, so responses can never overtake each other.
    assign stall = (cnt_q == CntW'(NumOutstanding)) ||
                   ((cnt_q != '0) && (target != cur_tgt_q));

    // Request path
    always_comb begin
        slv_req_o = '0;
        gnt_o     = 1'b0;
        if (req_i && !stall && !rst_i) begin
            if (target == TgtErr) begin
                gnt_o = 1'b1;
            end else begin
                slv_req_o[target] = 1'b1;
                gnt_o             = slv_gnt_i[target];
            end
        end
    end

    assign slv_addr_o  = addr_i;
    assign slv_we_o    = we_i;
    assign slv_be_o    = be_i;
    assign slv_wdata_o = wdata_i;

    // Response path: follow whichever target currently owns the ordering slot
    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = '0;
        err_o    = 1'b0;
        if (!rst_i) begin
            if (cur_tgt_q == TgtErr) begin
                rvalid_o = err_rvalid_q;
                err_o    = err_rvalid_q;
                rdata_o  = err_rvalid_q ? DataWidth'(ErrData) : '0;
            end else begin
                for (int i = 0; i < NumSlaves; i++) begin
                    if (cur_tgt_q == 4'(i)) begin
                        rvalid_o = slv_rvalid_i[i];
                        rdata_o  = slv_rdata_i[i*DataWidth +: DataWidth];
                        err_o    = slv_err_i[i];
                    end
                end
            end
        end
    end

    assign rvalid_dec = rvalid_o && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_o && !rvalid_dec) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!gnt_o && rvalid_dec) begin
            cnt_d = cnt_q - CntW'(1);
        end
        cur_tgt_d    = gnt_o ? target : cur_tgt_q;
        // Unmapped accesses answer exactly one cycle after their grant.
        err_rvalid_d = gnt_o && (target == TgtErr);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            cur_tgt_q    <= '0;
            err_rvalid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_tgt_q    <= cur_tgt_d;
            err_rvalid_q <= err_rvalid_d;
        end
    end

    always_comb begin
        cur_mask = '0;
        if (cur_tgt_q != TgtErr) begin
            cur_mask[cur_tgt_q] = 1'b1;
        end
    end

    // Only the current target may respond; anything else is dropped.
    a_rvalid_from_cur_tgt : assert property (@(posedge clk_i) disable iff (rst_i)
        (slv_rvalid_i & ~cur_mask) == '0)
        else $error("soc_periph_demux: slv_rvalid_i from non-current slave");

`ifdef SOC_PERIPH_DEMUX_ERR_CAPTURE_EN
    localparam int unsigned PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

    // Addresses of granted requests in grant order; the head belongs to the
    // oldest outstanding transaction, i.e. the one whose response is next.
    logic [AddrWidth-1:0] addr_fifo_q [NumOutstanding];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic                 err_valid_q, err_valid_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d    = gnt_o ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = rvalid_dec ? next_ptr(rd_ptr_q) : rd_ptr_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clr_i) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end else if (!err_valid_q) begin
            // ERR responses were already recorded at their grant.
            if (rvalid_dec && err_o && (cur_tgt_q != TgtErr)) begin
                err_valid_d = 1'b1;
                err_addr_d  = addr_fifo_q[rd_ptr_q];
            end else if (gnt_o && (target == TgtErr)) begin
                err_valid_d = 1'b1;
                err_addr_d  = addr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_o) begin
            addr_fifo_q[wr_ptr_q] <= addr_i;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`endif

endmodule

// File: tb/tb_soc_periph_demux.sv
// tb/tb_soc_periph_demux.sv - self-checking bench for soc_periph_demux

module tb_soc_periph_demux;

    localparam int NS = 11;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam logic [63:0] ERR_DATA = 64'hBADC_AB1E_BADC_AB1E;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_i;
    logic [AW-1:0]     addr_i;
    logic              we_i;
    logic [DW/8-1:0]   be_i;
    logic [DW-1:0]     wdata_i;
    logic              gnt_o;
    logic              rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic [NS-1:0]     slv_req_o;
    logic [AW-1:0]     slv_addr_o;
    logic              slv_we_o;
    logic [DW/8-1:0]   slv_be_o;
    logic [DW-1:0]     slv_wdata_o;
    logic [NS-1:0]     slv_gnt_i;
    logic [NS-1:0]     slv_rvalid_i;
    logic [NS*DW-1:0]  slv_rdata_i;
    logic [NS-1:0]     slv_err_i;
`ifdef SOC_PERIPH_DEMUX_ERR_CAPTURE_EN
    logic              err_valid_o;
    logic [AW-1:0]     err_addr_o;
    logic              err_clr_i;
`endif

    soc_periph_demux dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .slv_req_o    (slv_req_o),
        .slv_addr_o   (slv_addr_o),
        .slv_we_o     (slv_we_o),
        .slv_be_o     (slv_be_o),
        .slv_wdata_o  (slv_wdata_o),
        .slv_gnt_i    (slv_gnt_i),
        .slv_rvalid_i (slv_rvalid_i),
        .slv_rdata_i  (slv_rdata_i),
        .slv_err_i    (slv_err_i)
`ifdef SOC_PERIPH_DEMUX_ERR_CAPTURE_EN
        ,
        .err_valid_o  (err_valid_o),
        .err_addr_o   (err_addr_o),
        .err_clr_i    (err_clr_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        slv_gnt_i = '0; slv_rvalid_i = '0; slv_rdata_i = '0; slv_err_i = '0;
`ifdef SOC_PERIPH_DEMUX_ERR_CAPTURE_EN
        err_clr_i = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Address map reference, indexed by slave number
    logic [63:0] m_base [NS];
    logic [63:0] m_len  [NS];

    function automatic int ref_decode(input logic [63:0] a);
        for (int t = 0; t < NS; t++) begin
            if ({1'b0, a} >= {1'b0, m_base[t]} && {1'b0, a} < ({1'b0, m_base[t]} + {1'b0, m_len[t]}))
                return t;
        end
        return 11;
    endfunction

    function automatic logic [63:0] rand_addr(input int pick);
        int r;
        r = int'($urandom_range(9));
        if (pick == 11) begin
            case (r % 4)
                0:       return 64'h6000_0000 + 64'($urandom_range(4095));
                1:       return 64'h0000_1000 + 64'($urandom_range(255));
                2:       return 64'hC000_0000;
                default: return {32'h0000_0001 + 32'($urandom_range(7)), $urandom};
            endcase
        end
        if (r == 0) return m_base[pick];
        if (r == 1) return m_base[pick] + m_len[pick] - 64'd1;
        if (r == 2) return m_base[pick] + m_len[pick];
        return m_base[pick] + (64'($urandom) % m_len[pick]);
    endfunction

    function automatic logic [63:0] slv_data(input logic [63:0] a, input int t);
        return {32'(t) ^ 32'hC0DE_0000, a[31:0]};
    endfunction

    typedef struct {
        logic [63:0]   addr;
        logic [NS-1:0] exp_req;
        logic          exp_gnt;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } resp_t;

    vec_t        vecs[$];
    logic [63:0] sq [NS][$];
    resp_t       expq[$];

    function automatic vec_t mk(input logic [63:0] a, input int tgt);
        vec_t v;
        v.addr    = a;
        v.exp_req = (tgt == 11) ? '0 : (NS'(1) << tgt);
        v.exp_gnt = (tgt == 11);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_base[10] = 64'h0;          m_len[10] = 64'h1000;
        m_base[9]  = 64'h1_0000;     m_len[9]  = 64'h1_0000;
        m_base[8]  = 64'h200_0000;   m_len[8]  = 64'hC_0000;
        m_base[7]  = 64'hC00_0000;   m_len[7]  = 64'h3FF_FFFF;
        m_base[6]  = 64'h1000_0000;  m_len[6]  = 64'h1000;
        m_base[5]  = 64'h1800_0000;  m_len[5]  = 64'h1000;
        m_base[4]  = 64'h2000_0000;  m_len[4]  = 64'h80_0000;
        m_base[3]  = 64'h3000_0000;  m_len[3]  = 64'h1_0000;
        m_base[2]  = 64'h4000_0000;  m_len[2]  = 64'h1000;
        m_base[0]  = 64'h5000_0000;  m_len[0]  = 64'h3FF_FFFF;
        m_base[1]  = 64'h8000_0000;  m_len[1]  = 64'h4000_0000;

        vecs.push_back(mk(64'h0000_0000, 10));
        vecs.push_back(mk(64'h0000_0FFF, 10));
        vecs.push_back(mk(64'h0000_1000, 11));
        vecs.push_back(mk(64'h0001_0000, 9));
        vecs.push_back(mk(64'h0001_FFFF, 9));
        vecs.push_back(mk(64'h0002_0000, 11));
        vecs.push_back(mk(64'h0200_0000, 8));
        vecs.push_back(mk(64'h020B_FFFF, 8));
        vecs.push_back(mk(64'h020C_0000, 11));
        vecs.push_back(mk(64'h0C00_0000, 7));
        vecs.push_back(mk(64'h0FFF_FFFE, 7));
        vecs.push_back(mk(64'h0FFF_FFFF, 11));
        vecs.push_back(mk(64'h1000_0000, 6));
        vecs.push_back(mk(64'h1000_1000, 11));
        vecs.push_back(mk(64'h1800_0FFF, 5));
        vecs.push_back(mk(64'h2000_0000, 4));
        vecs.push_back(mk(64'h207F_FFFF, 4));
        vecs.push_back(mk(64'h2080_0000, 11));
        vecs.push_back(mk(64'h3000_FFFF, 3));
        vecs.push_back(mk(64'h4000_0000, 2));
        vecs.push_back(mk(64'h5000_0000, 0));
        vecs.push_back(mk(64'h53FF_FFFE, 0));
        vecs.push_back(mk(64'h53FF_FFFF, 11));
        vecs.push_back(mk(64'h6000_0000, 11));
        vecs.push_back(mk(64'h8000_0000, 1));
        vecs.push_back(mk(64'hBFFF_FFFF, 1));
        vecs.push_back(mk(64'hC000_0000, 11));
        vecs.push_back(mk(64'h1_8000_0000, 11));
        vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 11));

        // Outputs gated while in reset, even with a responding slave
        idle_inputs();
        rst_i = 1'b1;
        req_i = 1'b1; addr_i = 64'h6000_0000;
        slv_gnt_i = '1; slv_rvalid_i = '1; slv_err_i = '1;
        slv_rdata_i = {NS{64'h1234_5678_9ABC_DEF0}};
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_req", 64'(slv_req_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_cnt", 64'(dut.cnt_q), 64'd0);
        do_reset();

        // Decode table: slv_gnt_i low, so only ERR grants
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_i);
            #1;
            req_i = 1'b1; addr_i = vecs[i].addr;
            @(negedge clk_i);
            chk($sformatf("dec_req[%h]", vecs[i].addr), 64'(slv_req_o), 64'(vecs[i].exp_req));
            chk($sformatf("dec_gnt[%h]", vecs[i].addr), 64'(gnt_o), 64'(vecs[i].exp_gnt));
            req_i = 1'b0;
        end
        do_reset();

        // UART read, response two cycles after grant
        req_i = 1'b1; addr_i = 64'h1000_0000; slv_gnt_i = NS'(1) << 6;
        @(negedge clk_i);
        chk("uart_req", 64'(slv_req_o), 64'h40);
        chk("uart_gnt", 64'(gnt_o), 64'd1);
        step();
        req_i = 1'b0; slv_gnt_i = '0;
        @(negedge clk_i);
        chk("uart_wait_rvalid", 64'(rvalid_o), 64'd0);
        step();
        slv_rvalid_i[6] = 1'b1; slv_rdata_i[6*DW +: DW] = 64'h41;
        @(negedge clk_i);
        chk("uart_rvalid", 64'(rvalid_o), 64'd1);
        chk("uart_rdata", rdata_o, 64'h41);
        chk("uart_err", 64'(err_o), 64'd0);
        step();
        slv_rvalid_i = '0;
        @(negedge clk_i);
        chk("uart_cnt", 64'(dut.cnt_q), 64'd0);

        // Unmapped read
        step();
        req_i = 1'b1; addr_i = 64'h6000_0000;
        @(negedge clk_i);
        chk("unmap_gnt", 64'(gnt_o), 64'd1);
        chk("unmap_req", 64'(slv_req_o), 64'd0);
        chk("unmap_rvalid0", 64'(rvalid_o), 64'd0);
        step();
        req_i = 1'b0;
        @(negedge clk_i);
        chk("unmap_rvalid1", 64'(rvalid_o), 64'd1);
        chk("unmap_rdata", rdata_o, ERR_DATA);
        chk("unmap_err", 64'(err_o), 64'd1);
        step();
        @(negedge clk_i);
        chk("unmap_rvalid2", 64'(rvalid_o), 64'd0);
        chk("unmap_cnt", 64'(dut.cnt_q), 64'd0);

        // Back-to-back ERR grants give back-to-back responses
        step();
        req_i = 1'b1; addr_i = 64'hC000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk($sformatf("b2b_gnt%0d", i), 64'(gnt_o), 64'd1);
            chk($sformatf("b2b_rvalid%0d", i), 64'(rvalid_o), (i == 0) ? 64'd0 : 64'd1);
            step();
        end
        req_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_rvalid_last", 64'(rvalid_o), 64'd1);
        step();
        @(negedge clk_i);
        chk("b2b_rvalid_end", 64'(rvalid_o), 64'd0);
        chk("b2b_cnt", 64'(dut.cnt_q), 64'd0);

        // Five DRAM reads against a silent DRAM: fifth stalls
        step();
        req_i = 1'b1; addr_i = 64'h8000_0000; slv_gnt_i = NS'(1) << 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("dram_gnt%0d", i), 64'(gnt_o), 64'd1);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk($sformatf("dram_stall_gnt%0d", i), 64'(gnt_o), 64'd0);
            chk($sformatf("dram_stall_req%0d", i), 64'(slv_req_o), 64'd0);
            step();
        end
        slv_rvalid_i[1] = 1'b1; slv_rdata_i[1*DW +: DW] = 64'hD0;
        @(negedge clk_i);
        chk("dram_rvalid", 64'(rvalid_o), 64'd1);
        step();
        slv_rvalid_i = '0;
        @(negedge clk_i);
        chk("dram_5th_gnt", 64'(gnt_o), 64'd1);
        step();
        req_i = 1'b0; slv_gnt_i = '0;
        slv_rvalid_i[1] = 1'b1;
        repeat (4) step();
        slv_rvalid_i = '0;
        @(negedge clk_i);
        chk("dram_drained", 64'(dut.cnt_q), 64'd0);

        // DRAM outstanding blocks a ROM request until drained
        step();
        req_i = 1'b1; addr_i = 64'h8000_0040; slv_gnt_i = NS'(1) << 1;
        @(negedge clk_i);
        chk("switch_dram_gnt", 64'(gnt_o), 64'd1);
        step();
        addr_i = 64'h0001_0000; slv_gnt_i = NS'(1) << 9;
        @(negedge clk_i);
        chk("switch_rom_held", 64'(slv_req_o), 64'd0);
        step();
        slv_rvalid_i[1] = 1'b1;
        @(negedge clk_i);
        chk("switch_rom_held2", 64'(slv_req_o), 64'd0);
        chk("switch_dram_rvalid", 64'(rvalid_o), 64'd1);
        step();
        slv_rvalid_i = '0;
        @(negedge clk_i);
        chk("switch_rom_req", 64'(slv_req_o), 64'h200);
        chk("switch_rom_gnt", 64'(gnt_o), 64'd1);
        step();
        req_i = 1'b0; slv_gnt_i = '0;
        slv_rvalid_i[9] = 1'b1; slv_rdata_i[9*DW +: DW] = 64'h900D;
        @(negedge clk_i);
        chk("switch_rom_rdata", rdata_o, 64'h900D);
        step();
        slv_rvalid_i = '0;

        // Reset with three outstanding DRAM reads
        req_i = 1'b1; addr_i = 64'h9000_0000; slv_gnt_i = NS'(1) << 1;
        repeat (3) step();
        @(negedge clk_i);
        chk("rst3_cnt_before", 64'(dut.cnt_q), 64'd3);
        rst_i = 1'b1; slv_rvalid_i[1] = 1'b1;
        #1;
        chk("rst3_gnt", 64'(gnt_o), 64'd0);
        chk("rst3_req", 64'(slv_req_o), 64'd0);
        chk("rst3_rvalid", 64'(rvalid_o), 64'd0);
        step();
        chk("rst3_cnt", 64'(dut.cnt_q), 64'd0);
        chk("rst3_rdata", rdata_o, 64'd0);
        idle_inputs();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst3_after_rvalid", 64'(rvalid_o), 64'd0);

`ifdef SOC_PERIPH_DEMUX_ERR_CAPTURE_EN
        chk("cap_reset", 64'(err_valid_o), 64'd0);
        step();
        req_i = 1'b1; addr_i = 64'h6000_0000;
        step();
        req_i = 1'b0;
        @(negedge clk_i);
        chk("cap_valid", 64'(err_valid_o), 64'd1);
        chk("cap_addr", err_addr_o, 64'h6000_0000);
        step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        @(negedge clk_i);
        chk("cap_clr_valid", 64'(err_valid_o), 64'd0);
        chk("cap_clr_addr", err_addr_o, 64'd0);
`endif

        // Randomized traffic against an ordering/occupancy reference
        do_reset();
        begin
            int          m_cnt = 0;
            int          m_cur = 0;
            logic        m_err_pend = 1'b0;
            logic        req_active = 1'b0;
            int          last_pick = 1;
            logic [NS-1:0] hs;
            logic [NS-1:0] rv_now;
            for (int t = 0; t < NS; t++) sq[t].delete();
            expq.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                for (int t = 0; t < NS; t++) begin
                    if (sq[t].size() > 0 && $urandom_range(3) == 0) begin
                        slv_rvalid_i[t] = 1'b1;
                        slv_rdata_i[t*DW +: DW] = slv_data(sq[t][0], t);
                        slv_err_i[t] = sq[t][0][4];
                    end else begin
                        slv_rvalid_i[t] = 1'b0;
                        slv_rdata_i[t*DW +: DW] = '0;
                        slv_err_i[t] = 1'b0;
                    end
                end
                slv_gnt_i = NS'($urandom | $urandom);
                if (!req_active) begin
                    req_i = 1'b0;
                    if ($urandom_range(2) != 0) begin
                        int sel;
                        sel = int'($urandom_range(9));
                        if (sel < 5) last_pick = last_pick;
                        else if (sel == 5) last_pick = 11;
                        else if (sel == 6) last_pick = 9;
                        else if (sel == 7) last_pick = 6;
                        else last_pick = int'($urandom_range(10));
                        addr_i  = rand_addr(last_pick);
                        we_i    = 1'($urandom);
                        be_i    = 8'($urandom);
                        wdata_i = {$urandom, $urandom};
                        req_i   = 1'b1;
                        req_active = 1'b1;
                    end
                end
                @(negedge clk_i);
                begin
                    int          e_tgt;
                    logic        e_stall;
                    logic [NS-1:0] e_req;
                    logic        e_gnt;
                    logic        e_rv;
                    e_tgt   = ref_decode(addr_i);
                    e_stall = (m_cnt == 4) || (m_cnt != 0 && e_tgt != m_cur);
                    e_req   = (req_i && !e_stall && e_tgt < 11) ? (NS'(1) << e_tgt) : '0;
                    e_gnt   = req_i && !e_stall && ((e_tgt == 11) || slv_gnt_i[e_tgt]);
                    if (m_cur == 11) e_rv = m_err_pend;
                    else e_rv = slv_rvalid_i[m_cur];
                    chk("rnd_slv_req", 64'(slv_req_o), 64'(e_req));
                    chk("rnd_gnt", 64'(gnt_o), 64'(e_gnt));
                    chk("rnd_rvalid", 64'(rvalid_o), 64'(e_rv));
                    if (req_i) chk("rnd_bcast_addr", slv_addr_o, addr_i);
                    if (e_rv) begin
                        if (expq.size() == 0) begin
                            chk("rnd_resp_queue", 64'd0, 64'd1);
                        end else begin
                            resp_t r;
                            r = expq.pop_front();
                            chk("rnd_rdata", rdata_o, r.data);
                            chk("rnd_err", 64'(err_o), 64'(r.err));
                        end
                        m_cnt--;
                    end
                    hs     = e_req & slv_gnt_i;
                    rv_now = slv_rvalid_i;
                    m_err_pend = 1'b0;
                    if (e_gnt) begin
                        resp_t r;
                        if (e_tgt == 11) begin
                            r.data = ERR_DATA; r.err = 1'b1;
                            m_err_pend = 1'b1;
                        end else begin
                            r.data = slv_data(addr_i, e_tgt); r.err = addr_i[4];
                        end
                        expq.push_back(r);
                        m_cnt++;
                        m_cur = e_tgt;
                        req_active = 1'b0;
                    end
                end
                step();
                for (int t = 0; t < NS; t++) begin
                    if (rv_now[t]) void'(sq[t].pop_front());
                    if (hs[t]) sq[t].push_back(addr_i);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
